uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- Receive-side buffer directly downstream of the UART core.
- Consumes the core's parallel receive output (9-bit word plus a one-cycle valid strobe) and stores words in a first-word-fall-through (FWFT) FIFO.
- Tracks receive errors with a saturating counter and flags overflow with a sticky bit.
- Presents a ready/valid read port to the host-side logic.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ERR_CNT_W, 8, error counter width.
- DROP_ERR, 0, 1 = errored words are counted but not stored; 0 = errored words are stored with their error flag.

Ports:
- clk  in  1  system clock, same clock as the UART core.
- rst  in  1  reset; one clock, synchronous, active-high.
- PalDataOut  in  9  receive word from the UART core; [7:0] data byte, [8] = 1 means parity/frame error.
- PalDataOutValid  in  1  one-cycle strobe; PalDataOut is valid while it is high.
- rd_data  out  8  data byte at the FIFO head.
- rd_err  out  1  error flag at the FIFO head.
- rd_valid  out  1  head entry valid.
- rd_ready  in  1  consumer accepts the head entry.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a word was lost because the FIFO was full.
- ovf_clr  in  1  clears overflow.
- err_cnt  out  ERR_CNT_W  number of words received with [8] = 1; saturates at all-ones.
- err_cnt_clr  in  1  clears err_cnt.

Behaviour:
- Reset (rst = 1 at a clk edge) values:
  - pointers = 0, count = 0, empty = 1, full = 0;
  - rd_valid = 0, rd_data = 0, rd_err = 0;
  - overflow = 0, err_cnt = 0.
  - Reset asserted mid-operation discards all stored words immediately; storage RAM contents need not be cleared.
- Push request: PalDataOutValid = 1 and not (DROP_ERR = 1 and PalDataOut[8] = 1).
- Pop: rd_valid & rd_ready.
- FWFT read port:
  - rd_valid = !empty;
  - rd_data/rd_err reflect the entry at the read pointer, combinationally from registered state;
  - pointer and count update on the edge.
- Latency: a word strobed at edge N gives rd_valid = 1 after edge N when the FIFO was empty. There is no same-cycle bypass from PalDataOutValid to rd_valid.
- Head stability: while rd_valid = 1 and rd_ready = 0, rd_data/rd_err stay stable.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count arithmetic:
  - count += push accepted, −= pop;
  - push and pop in the same cycle leave count unchanged.
- Full boundary:
  - push with full = 1 and no pop: word dropped, overflow set to 1, count stays DEPTH.
  - push with full = 1 and pop in the same cycle: push accepted, no overflow.
- Empty boundary:
  - rd_ready = 1 with empty = 1 has no effect; count never underflows.
  - push while empty with rd_ready = 1 stores the word; it pops on a later cycle.
- overflow: once set, holds until ovf_clr. If ovf_clr and a new overflow event occur in the same cycle, set wins (overflow = 1).
- err_cnt:
  - increments by 1 on any PalDataOutValid with PalDataOut[8] = 1, whether or not the word is stored or dropped for overflow.
  - holds at 2^ERR_CNT_W − 1.
  - err_cnt_clr alone gives 0; err_cnt_clr together with an error event gives 1.
- PalDataOut is ignored when PalDataOutValid = 0.

Test Plan:
- Basic order: rst, then strobe 0x41, 0x42, 0x43 (bit8 = 0) with rd_ready = 0 → count = 3, rd_data = 0x41, rd_valid = 1. Then rd_ready = 1 for 3 cycles → 0x41, 0x42, 0x43 in order, then empty = 1, rd_valid = 0.
- Overflow (DEPTH = 16): 17 strobes 0x00..0x10 with rd_ready = 0 → full = 1, overflow = 1, count = 16. Drain returns 0x00..0x0F; 0x10 lost. ovf_clr → overflow = 0.
- Full with simultaneous push/pop: fill to 16, then strobe 0xAA with rd_ready = 1 in the same cycle → no overflow, count = 16. 0xAA emerges as the 16th word after the pop.
- Error handling:
  - DROP_ERR = 0: strobe 0x155 → rd_data = 0x55, rd_err = 1, err_cnt = 1.
  - DROP_ERR = 1: same strobe → empty stays 1, err_cnt = 1.
- Saturation/clear (ERR_CNT_W = 4): 20 error strobes → err_cnt = 15. err_cnt_clr alone → 0. err_cnt_clr coinciding with an error strobe → 1.
- Mid-operation reset: load 5 words, assert rst for one cycle during a strobe → count = 0, empty = 1, overflow = 0, err_cnt = 0, rd_valid = 0. The first post-reset strobe 0x7E reads back as 0x7E.

Source files
------------

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - receive-side FWFT buffer behind the UART core
// Stores received words, counts receive errors and flags lost words on overflow.
module uart_rx_buffer #(
  parameter int DEPTH     = 16,
  parameter int ERR_CNT_W = 8,
  parameter int DROP_ERR  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8:0]                PalDataOut,
  input  logic                      PalDataOutValid,
  output logic [7:0]                rd_data,
  output logic                      rd_err,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  input  logic                      err_cnt_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]           mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 push_req, push, pop, err_evt, ovf_evt;
  logic [8:0]           head;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    rd_valid = !empty;
    push_req = PalDataOutValid && !((DROP_ERR != 0) && PalDataOut[8]);
    pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push     = push_req && (!full || pop);
    ovf_evt  = push_req && full && !pop;
    err_evt  = PalDataOutValid && PalDataOut[8];

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = (ovf_q && !ovf_clr) || ovf_evt;

    err_cnt_d = err_cnt_clr ? '0 : err_cnt_q;
    if (err_evt && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is not reset; the empty gate below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= PalDataOut;
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr_q];
    rd_data  = empty ? 8'h00 : head[7:0];
    rd_err   = empty ? 1'b0  : head[8];
    count    = count_q;
    overflow = ovf_q;
    err_cnt  = err_cnt_q;
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - scoreboard bench for uart_rx_buffer
// Main instance keeps errored words (4-bit error counter); second instance drops them.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] din = '0;
  logic       dv  = 1'b0;
  logic       rdy = 1'b0;
  logic       oc  = 1'b0;
  logic       ec  = 1'b0;

  logic [7:0] rd_data, rd_data2;
  logic       rd_err, rd_err2, rd_valid, rd_valid2;
  logic [4:0] count, count2;
  logic       full, full2, empty, empty2, overflow, overflow2;
  logic [3:0] err_cnt;
  logic [7:0] err_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  int mcount = 0;
  int vis = 0;

  always #5 clk = ~clk;

  uart_rx_buffer #(.DEPTH(16), .ERR_CNT_W(4), .DROP_ERR(0)) dut (
    .clk(clk), .rst(rst), .PalDataOut(din), .PalDataOutValid(dv),
    .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid), .rd_ready(rdy),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .ovf_clr(oc),
    .err_cnt(err_cnt), .err_cnt_clr(ec)
  );

  uart_rx_buffer #(.DEPTH(16), .ERR_CNT_W(8), .DROP_ERR(1)) dut_drop (
    .clk(clk), .rst(rst), .PalDataOut(din), .PalDataOutValid(dv),
    .rd_data(rd_data2), .rd_err(rd_err2), .rd_valid(rd_valid2), .rd_ready(rdy),
    .count(count2), .full(full2), .empty(empty2), .overflow(overflow2), .ovf_clr(oc),
    .err_cnt(err_cnt2), .err_cnt_clr(ec)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one clock of stimulus; the expected word is queued when the model accepts it.
  task automatic cyc(input logic v, input logic [8:0] w, input logic r, input logic o, input logic e);
    logic pop;
    dv = v; din = w; rdy = r; oc = o; ec = e;
    vis = mcount;
    pop = (mcount > 0) && r;
    if (v && (mcount < 16 || pop)) begin
      exp_q.push_back(w);
      mcount++;
    end
    if (pop) mcount--;
    @(posedge clk); #1;
    dv = 1'b0; oc = 1'b0; ec = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rst_cyc(input logic v, input logic [8:0] w);
    rst = 1'b1; dv = v; din = w; rdy = 1'b0;
    exp_q.delete(); mcount = 0; vis = 0;
    @(posedge clk); #1;
    rst = 1'b0; dv = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_valid vs model", 32'(rd_valid), 32'(vis > 0));
      if (rd_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop: got 0x%0h expected no pop", {rd_err, rd_data});
        end else begin
          chk("pop word", 32'({rd_err, rd_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(empty), 1);
    chk("rst full", 32'(full), 0);
    chk("rst rd_valid", 32'(rd_valid), 0);
    chk("rst rd_data", 32'(rd_data), 0);
    chk("rst rd_err", 32'(rd_err), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst err_cnt", 32'(err_cnt), 0);

    cyc(1'b1, 9'h041, 1'b0, 1'b0, 1'b0);
    chk("latency rd_valid", 32'(rd_valid), 1);
    cyc(1'b1, 9'h042, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h043, 1'b0, 1'b0, 1'b0);
    chk("basic count", 32'(count), 3);
    chk("basic head", 32'(rd_data), 32'h41);
    drain(3);
    chk("basic empty", 32'(empty), 1);
    chk("basic rd_valid", 32'(rd_valid), 0);
    drain(1);
    chk("underflow count", 32'(count), 0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 9'(i), 1'b0, 1'b0, 1'b0);
    chk("fill count", 32'(count), 16);
    chk("fill full", 32'(full), 1);
    chk("fill overflow", 32'(overflow), 0);
    cyc(1'b1, 9'h010, 1'b0, 1'b0, 1'b0);
    chk("ovf overflow", 32'(overflow), 1);
    chk("ovf count", 32'(count), 16);
    drain(16);
    chk("ovf drained empty", 32'(empty), 1);
    chk("ovf sticky", 32'(overflow), 1);
    cyc(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    chk("ovf clear", 32'(overflow), 0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 9'(32'h20 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h0AA, 1'b1, 1'b0, 1'b0);
    chk("full push+pop overflow", 32'(overflow), 0);
    chk("full push+pop count", 32'(count), 16);
    drain(16);
    chk("full push+pop empty", 32'(empty), 1);

    cyc(1'b1, 9'h033, 1'b1, 1'b0, 1'b0);
    chk("push on empty count", 32'(count), 1);
    drain(1);

    cyc(1'b1, 9'h155, 1'b0, 1'b0, 1'b0);
    chk("err rd_data", 32'(rd_data), 32'h55);
    chk("err rd_err", 32'(rd_err), 1);
    chk("err err_cnt", 32'(err_cnt), 1);
    chk("drop empty", 32'(empty2), 1);
    chk("drop err_cnt", 32'(err_cnt2), 1);
    drain(1);

    for (int i = 0; i < 20; i++) cyc(1'b1, 9'h100 | 9'(i), 1'b1, 1'b0, 1'b0);
    chk("err_cnt saturate", 32'(err_cnt), 15);
    chk("drop err_cnt 21", 32'(err_cnt2), 21);
    drain(2);
    cyc(1'b0, 9'h000, 1'b1, 1'b0, 1'b1);
    chk("err_cnt clr", 32'(err_cnt), 0);
    cyc(1'b1, 9'h1EE, 1'b1, 1'b0, 1'b1);
    chk("err_cnt clr+err", 32'(err_cnt), 1);
    drain(2);

    for (int i = 0; i < 16; i++) cyc(1'b1, 9'(32'h60 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9'h0BB, 1'b0, 1'b1, 1'b0);
    chk("ovf set beats clr", 32'(overflow), 1);
    drain(16);

    for (int i = 0; i < 5; i++) cyc(1'b1, 9'(32'h70 + i), 1'b0, 1'b0, 1'b0);
    rst_cyc(1'b1, 9'h1FF);
    chk("midrst count", 32'(count), 0);
    chk("midrst empty", 32'(empty), 1);
    chk("midrst overflow", 32'(overflow), 0);
    chk("midrst err_cnt", 32'(err_cnt), 0);
    chk("midrst rd_valid", 32'(rd_valid), 0);
    cyc(1'b1, 9'h07E, 1'b0, 1'b0, 1'b0);
    chk("post rst head", 32'(rd_data), 32'h7E);
    drain(1);
    chk("post rst empty", 32'(empty), 1);
    chk("scoreboard empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
